// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension pipeline: extension modes
// and skid-buffer states.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN  = 2'b00,
    MODE_ZERO  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension.
// Optional macro IMM_EXT_LUI_EN: when defined, mode 10 places the immediate
// in bits 2*IN_W-1..IN_W; when undefined, mode 10 is reserved and no shifter
// exists. Reserved modes produce a sign extension with err=1.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  // Select the extension by mode; unsupported modes fall back to sign extension.
  always_comb begin
    data = OUT_W'($signed(imm));
    err  = 1'b0;
    case (mode)
      MODE_SIGN: data = OUT_W'($signed(imm));
      MODE_ZERO: data = OUT_W'(imm);
`ifdef IMM_EXT_LUI_EN
      MODE_UPPER: data = OUT_W'(imm) << IN_W;
`endif
      default: begin
        data = OUT_W'($signed(imm));
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension pipeline: extension at input acceptance followed by a
// two-entry skid buffer (main register drives outputs, skid holds overflow).
// Optional macro IMM_EXT_LUI_EN enables upper (LUI) placement in mode 10.
//
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side; valid never depends on ready, and ready/valid come from the state
// register (in_ready is additionally forced low while reset is asserted).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  state_e           state;
  logic [OUT_W-1:0] main_data;
  logic             main_err;
  logic [OUT_W-1:0] skid_data;
  logic             skid_err;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm (in_imm),
    .mode(in_mode),
    .data(ext_data),
    .err (ext_err)
  );

  // Ready/valid from the state register; reset gating keeps in_ready low in reset.
  always_comb begin
    in_ready  = rst_n && (state != ST_TWO);
    out_valid = (state != ST_EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = main_data;
    out_err   = main_err;
  end

  // Skid-buffer FSM: loads main or skid on accept, shifts skid into main on pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            main_data <= ext_data;
            main_err  <= ext_err;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_data <= ext_data;
            main_err  <= ext_err;
          end else if (push) begin
            skid_data <= ext_data;
            skid_err  <= ext_err;
            state     <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            state     <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed testbench for imm_ext_pipe: default 16->32 instance plus an
// 8->16 instance. Expectations for mode 10 follow IMM_EXT_LUI_EN.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_imm8;
  logic [1:0]  in_mode8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] out_data8;
  logic        out_err8;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  imm_ext_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_imm   (in_imm8),
    .in_mode  (in_mode8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .out_data (out_data8),
    .out_err  (out_err8)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one immediate with an idle consumer path and check the next-cycle result
  task automatic send_one(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp_data, input logic exp_err);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_data"}, 64'(out_data), 64'(exp_data));
    check({tag, "_err"}, 64'(out_err), 64'(exp_err));
    tick();
    check({tag, "_drain"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_imm      = '0;
    in_mode     = 2'b00;
    out_ready   = 1'b1;
    in_valid8   = 1'b0;
    in_imm8     = '0;
    in_mode8    = 2'b00;
    out_ready8  = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    // Extension modes
    send_one("sign_8001", 16'h8001, 2'b00, 32'hFFFF8001, 1'b0);
    send_one("zero_8001", 16'h8001, 2'b01, 32'h00008001, 1'b0);
    send_one("sign_7fff", 16'h7FFF, 2'b00, 32'h00007FFF, 1'b0);
`ifdef IMM_EXT_LUI_EN
    send_one("upper_1234", 16'h1234, 2'b10, 32'h12340000, 1'b0);
`else
    send_one("upper_1234", 16'h1234, 2'b10, 32'h00001234, 1'b1);
`endif
    send_one("rsvd_ffff", 16'hFFFF, 2'b11, 32'hFFFFFFFF, 1'b1);

    // Backpressure: two entries held, third offer ignored, drained in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_imm    = 16'h0001;
    tick();
    check("bp1_in_ready", 64'(in_ready), 64'(1));
    check("bp1_data", 64'(out_data), 64'(32'h1));
    in_imm = 16'h0002;
    tick();
    check("bp2_in_ready", 64'(in_ready), 64'(0));
    check("bp2_data_hold", 64'(out_data), 64'(32'h1));
    in_imm = 16'h0003;
    tick();
    check("bp3_in_ready", 64'(in_ready), 64'(0));
    check("bp3_data_hold", 64'(out_data), 64'(32'h1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_pop1_valid", 64'(out_valid), 64'(1));
    check("bp_pop1_data", 64'(out_data), 64'(32'h2));
    check("bp_pop1_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("bp_pop2_empty", 64'(out_valid), 64'(0));

    // Sustained throughput: imm 0..7 delivered on consecutive cycles
    in_valid = 1'b1;
    in_mode  = 2'b01;
    for (int i = 0; i < 8; i++) begin
      in_imm = 16'(i);
      exp_q.push_back(32'(i));
      tick();
      check("thr_valid", 64'(out_valid), 64'(1));
      check("thr_in_ready", 64'(in_ready), 64'(1));
      check("thr_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
    in_valid = 1'b0;
    tick();
    check("thr_drain", 64'(out_valid), 64'(0));

    // Reset while holding two entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'hFFFF;
    in_mode   = 2'b11;
    tick();
    in_imm  = 16'h00AA;
    in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    check("two_in_ready", 64'(in_ready), 64'(0));
    check("two_err", 64'(out_err), 64'(1));
    rst_n = 1'b0;
    tick();
    check("mrst_out_valid", 64'(out_valid), 64'(0));
    check("mrst_out_data", 64'(out_data), 64'(0));
    check("mrst_out_err", 64'(out_err), 64'(0));
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mrst_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("mrst_no_stale", 64'(out_valid), 64'(0));

    // Narrow instance 8 -> 16
    in_valid8 = 1'b1;
    in_imm8   = 8'h80;
    in_mode8  = 2'b00;
    tick();
    check("n8_sign_data", 64'(out_data8), 64'(16'hFF80));
    check("n8_sign_err", 64'(out_err8), 64'(0));
    in_mode8 = 2'b10;
    tick();
    in_valid8 = 1'b0;
`ifdef IMM_EXT_LUI_EN
    check("n8_upper_data", 64'(out_data8), 64'(16'h8000));
    check("n8_upper_err", 64'(out_err8), 64'(0));
`else
    check("n8_upper_data", 64'(out_data8), 64'(16'hFF80));
    check("n8_upper_err", 64'(out_err8), 64'(1));
`endif
    tick();
    check("n8_drain", 64'(out_valid8), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
